// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: CSR addresses, mstatus bit positions, FSM states, entry layout.
// WBU_COUNTERS_EN adds the mcycle/minstret addresses and makes them known to csr_known().
package wb_stage_pkg;

  localparam logic [31:0] CSR_MSTATUS_RST = 32'h0000_1800;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef WBU_COUNTERS_EN
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
`endif

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        irq;
    logic [3:0]  irq_no;
    logic        gpr_we;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        is_break;
  } wb_entry_t;

  function automatic logic csr_known(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: return 1'b1;
`ifdef WBU_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_csr_file.sv
// Machine CSR file: mstatus/mtvec/mepc/mcause, trap capture, read mux with commit bypass (WBU_COUNTERS_EN adds counters).
// Writes land at the edge ending the commit cycle; reads are combinational and see the committing write.
module wb_csr_file
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic        irq,
  input  logic [3:0]  irq_no,
  input  logic [31:0] pc,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic [31:0] mtvec
);

  logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
  logic [31:0] wr_val;
  logic        wr_en, trap;

  // A trapping entry never performs its own CSR write.
  assign trap   = commit & irq;
  assign wr_en  = commit & csr_we & ~irq;
  assign wr_val = (csr_waddr == CSR_MTVEC) ? {csr_wdata[31:2], 2'b00} : csr_wdata;
  assign mtvec  = mtvec_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstatus_q <= CSR_MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      if (wr_en) begin
        case (csr_waddr)
          CSR_MSTATUS: mstatus_q <= wr_val;
          CSR_MTVEC:   mtvec_q   <= wr_val;
          CSR_MEPC:    mepc_q    <= wr_val;
          CSR_MCAUSE:  mcause_q  <= wr_val;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_q                  <= pc;
        mcause_q                <= {28'd0, irq_no};
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end
    end
  end

`ifdef WBU_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A software write to either half replaces the increment for that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && csr_waddr == CSR_MCYCLE)        mcycle_q[31:0]  <= csr_wdata;
      else if (wr_en && csr_waddr == CSR_MCYCLEH)  mcycle_q[63:32] <= csr_wdata;
      else                                          mcycle_q        <= mcycle_q + 64'd1;
      if (wr_en && csr_waddr == CSR_MINSTRET)       minstret_q[31:0]  <= csr_wdata;
      else if (wr_en && csr_waddr == CSR_MINSTRETH) minstret_q[63:32] <= csr_wdata;
      else if (commit && !irq)                      minstret_q        <= minstret_q + 64'd1;
    end
  end
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
`ifdef WBU_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
      default:       csr_rdata = '0;
    endcase
    if (wr_en && csr_waddr == csr_raddr && csr_known(csr_raddr)) csr_rdata = wr_val;
    if (trap && csr_raddr == CSR_MEPC)   csr_rdata = pc;
    if (trap && csr_raddr == CSR_MCAUSE) csr_rdata = {28'd0, irq_no};
  end

endmodule

// File: rtl/wb_stage.sv
// Single-entry write-back buffer committing to the GPR port and CSR file; WBU_COUNTERS_EN adds mcycle/minstret.
// Accept at edge N, commit in cycle N+1; commit_ready low holds the entry and drops wb_in_ready.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_in_valid,
  output logic        wb_in_ready,
  input  logic [31:0] pc_i,
  input  logic        irq_i,
  input  logic [3:0]  irq_no_i,
  input  logic        gpr_we_i,
  input  logic [3:0]  gpr_waddr_i,
  input  logic [31:0] gpr_wdata_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        is_break_i,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        trap_valid,
  output logic [31:0] trap_target,
  output logic        commit_valid,
  input  logic        commit_ready,
  output logic [31:0] commit_pc,
  output logic        commit_break,
  output logic        wb_fw_valid,
  output logic [3:0]  wb_fw_addr,
  output logic [31:0] wb_fw_data
);

  wb_state_e state_q, state_d;
  wb_entry_t entry_q, entry_d;
  logic      accept, commit_fire, gpr_live;

  assign commit_valid = (state_q == ST_FULL);
  assign commit_fire  = commit_valid & commit_ready;
  assign wb_in_ready  = (state_q == ST_EMPTY) | commit_fire;
  assign accept       = wb_in_valid & wb_in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (commit_fire && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    entry_d           = '0;
    entry_d.pc        = pc_i;
    entry_d.irq       = irq_i;
    entry_d.irq_no    = irq_no_i;
    entry_d.gpr_we    = gpr_we_i;
    entry_d.gpr_waddr = gpr_waddr_i;
    entry_d.gpr_wdata = gpr_wdata_i;
    entry_d.csr_we    = csr_we_i;
    entry_d.csr_waddr = csr_waddr_i;
    entry_d.csr_wdata = csr_wdata_i;
    entry_d.is_break  = is_break_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) entry_q <= entry_d;
    end
  end

  // x0 writes and trapping entries never reach the register file or the bypass network.
  assign gpr_live     = entry_q.gpr_we & ~entry_q.irq & (entry_q.gpr_waddr != 4'd0);
  assign rf_we        = commit_fire & gpr_live;
  assign rf_waddr     = entry_q.gpr_waddr;
  assign rf_wdata     = entry_q.gpr_wdata;
  assign trap_valid   = commit_fire & entry_q.irq;
  assign commit_pc    = entry_q.pc;
  assign commit_break = commit_valid & entry_q.is_break;
  assign wb_fw_valid  = commit_valid & gpr_live;
  assign wb_fw_addr   = entry_q.gpr_waddr;
  assign wb_fw_data   = entry_q.gpr_wdata;

  wb_csr_file u_csr (
    .clk       (clk),
    .reset     (reset),
    .commit    (commit_fire),
    .irq       (entry_q.irq),
    .irq_no    (entry_q.irq_no),
    .pc        (entry_q.pc),
    .csr_we    (entry_q.csr_we),
    .csr_waddr (entry_q.csr_waddr),
    .csr_wdata (entry_q.csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .mtvec     (trap_target)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commit, x0, trap, backpressure, CSR bypass, reset mid-hold, counters (WBU_COUNTERS_EN).
`timescale 1ns/1ps
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_in_valid, wb_in_ready;
  logic [31:0] pc_i;
  logic        irq_i;
  logic [3:0]  irq_no_i;
  logic        gpr_we_i;
  logic [3:0]  gpr_waddr_i;
  logic [31:0] gpr_wdata_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        is_break_i;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc;
  logic        commit_break;
  logic        wb_fw_valid;
  logic [3:0]  wb_fw_addr;
  logic [31:0] wb_fw_data;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .wb_in_valid(wb_in_valid), .wb_in_ready(wb_in_ready),
    .pc_i(pc_i), .irq_i(irq_i), .irq_no_i(irq_no_i),
    .gpr_we_i(gpr_we_i), .gpr_waddr_i(gpr_waddr_i), .gpr_wdata_i(gpr_wdata_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .is_break_i(is_break_i),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_break(commit_break),
    .wb_fw_valid(wb_fw_valid), .wb_fw_addr(wb_fw_addr), .wb_fw_data(wb_fw_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_raddr = addr;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  task automatic put(input logic [31:0] pc, input logic irq, input logic [3:0] no,
                     input logic gwe, input logic [3:0] ga, input logic [31:0] gd,
                     input logic cwe, input logic [11:0] ca, input logic [31:0] cd,
                     input logic brk);
    wb_in_valid = 1'b1;
    pc_i = pc; irq_i = irq; irq_no_i = no;
    gpr_we_i = gwe; gpr_waddr_i = ga; gpr_wdata_i = gd;
    csr_we_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
    is_break_i = brk;
  endtask

  task automatic idle();
    put(32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0);
    wb_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    commit_ready = 1'b1;
    csr_raddr = 12'h300;
    idle();
    repeat (2) tick();

    // reset state
    at_neg();
    check_eq("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_trap_valid", 32'(trap_valid), 32'd0);
    check_eq("rst_fw_valid", 32'(wb_fw_valid), 32'd0);
    check_eq("rst_in_ready", 32'(wb_in_ready), 32'd1);
    check_eq("rst_trap_target", trap_target, 32'h0);
    csr_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_chk("rst_mepc", 12'h341, 32'h0);
    tick();
    reset = 1'b1;

    // plain commit x5 <- DEADBEEF
    put(32'h100, 1'b0, 4'd0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0, 1'b0);
    at_neg();
    check_eq("t1_in_ready_empty", 32'(wb_in_ready), 32'd1);
    tick();
    idle();
    at_neg();
    check_eq("t1_commit_valid", 32'(commit_valid), 32'd1);
    check_eq("t1_rf_we", 32'(rf_we), 32'd1);
    check_eq("t1_rf_waddr", 32'(rf_waddr), 32'd5);
    check_eq("t1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    check_eq("t1_fw_valid", 32'(wb_fw_valid), 32'd1);
    check_eq("t1_fw_addr", 32'(wb_fw_addr), 32'd5);
    check_eq("t1_fw_data", wb_fw_data, 32'hDEAD_BEEF);
    check_eq("t1_commit_pc", commit_pc, 32'h100);
    tick();
    at_neg();
    check_eq("t1_empty_after", 32'(commit_valid), 32'd0);
    check_eq("t1_rf_we_after", 32'(rf_we), 32'd0);

    // x0 write is dropped
    put(32'h104, 1'b0, 4'd0, 1'b1, 4'd0, 32'h55, 1'b0, 12'h0, 32'h0, 1'b0);
    tick();
    idle();
    at_neg();
    check_eq("t2_commit_valid", 32'(commit_valid), 32'd1);
    check_eq("t2_rf_we_x0", 32'(rf_we), 32'd0);
    check_eq("t2_fw_valid_x0", 32'(wb_fw_valid), 32'd0);
    tick();

    // set MIE, then mtvec (low bits forced to 0), back to back
    put(32'h108, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 12'h300, 32'h0000_1808, 1'b0);
    tick();
    put(32'h10C, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 12'h305, 32'h8000_0103, 1'b0);
    at_neg();
    check_eq("t3_in_ready_b2b", 32'(wb_in_ready), 32'd1);
    csr_chk("t3_mstatus_bypass", 12'h300, 32'h0000_1808);
    tick();
    idle();
    at_neg();
    csr_chk("t3_mtvec_bypass", 12'h305, 32'h8000_0100);
    tick();
    at_neg();
    csr_chk("t3_mtvec", 12'h305, 32'h8000_0100);
    csr_chk("t3_mstatus", 12'h300, 32'h0000_1808);
    check_eq("t3_trap_target", trap_target, 32'h8000_0100);

    // trap commit: GPR and CSR writes of this entry suppressed
    put(32'h8000_0040, 1'b1, 4'd11, 1'b1, 4'd7, 32'h77, 1'b1, 12'h341, 32'hFFFF, 1'b0);
    tick();
    idle();
    at_neg();
    check_eq("t4_trap_valid", 32'(trap_valid), 32'd1);
    check_eq("t4_trap_target", trap_target, 32'h8000_0100);
    check_eq("t4_rf_we_irq", 32'(rf_we), 32'd0);
    check_eq("t4_fw_valid_irq", 32'(wb_fw_valid), 32'd0);
    csr_chk("t4_mepc_bypass", 12'h341, 32'h8000_0040);
    csr_chk("t4_mcause_bypass", 12'h342, 32'd11);
    tick();
    at_neg();
    check_eq("t4_trap_pulse_end", 32'(trap_valid), 32'd0);
    csr_chk("t4_mepc", 12'h341, 32'h8000_0040);
    csr_chk("t4_mcause", 12'h342, 32'd11);
    csr_chk("t4_mstatus", 12'h300, 32'h0000_1880);

    // backpressure for 3 cycles, then commit + accept together
    commit_ready = 1'b0;
    put(32'h200, 1'b0, 4'd0, 1'b1, 4'd3, 32'h333, 1'b0, 12'h0, 32'h0, 1'b1);
    tick();
    put(32'h204, 1'b0, 4'd0, 1'b1, 4'd4, 32'h444, 1'b0, 12'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check_eq("t5_stall_in_ready", 32'(wb_in_ready), 32'd0);
      check_eq("t5_stall_valid", 32'(commit_valid), 32'd1);
      check_eq("t5_stall_pc", commit_pc, 32'h200);
      check_eq("t5_stall_break", 32'(commit_break), 32'd1);
      check_eq("t5_stall_rf_we", 32'(rf_we), 32'd0);
      tick();
    end
    commit_ready = 1'b1;
    at_neg();
    check_eq("t5_release_rf_we", 32'(rf_we), 32'd1);
    check_eq("t5_release_waddr", 32'(rf_waddr), 32'd3);
    check_eq("t5_release_in_ready", 32'(wb_in_ready), 32'd1);
    tick();
    idle();
    at_neg();
    check_eq("t5_next_pc", commit_pc, 32'h204);
    check_eq("t5_next_waddr", 32'(rf_waddr), 32'd4);
    check_eq("t5_next_wdata", rf_wdata, 32'h444);
    check_eq("t5_next_break", 32'(commit_break), 32'd0);
    tick();
    at_neg();
    check_eq("t5_drained", 32'(commit_valid), 32'd0);

    // CSR write bypass, unknown address dropped
    put(32'h300, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 12'h341, 32'h1234, 1'b0);
    tick();
    idle();
    at_neg();
    csr_chk("t6_mepc_bypass", 12'h341, 32'h1234);
    tick();
    put(32'h304, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 12'h123, 32'hABCD, 1'b0);
    tick();
    idle();
    at_neg();
    csr_chk("t6_unknown_bypass", 12'h123, 32'h0);
    tick();
    at_neg();
    csr_chk("t6_unknown_read", 12'h123, 32'h0);
    csr_chk("t6_mepc_kept", 12'h341, 32'h1234);

    // reset while holding an entry, with an accept pending
    commit_ready = 1'b0;
    put(32'h400, 1'b0, 4'd0, 1'b1, 4'd9, 32'h99, 1'b0, 12'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    put(32'h500, 1'b0, 4'd0, 1'b1, 4'd10, 32'hAA, 1'b0, 12'h0, 32'h0, 1'b0);
    at_neg();
    check_eq("t7_hold_rf_we", 32'(rf_we), 32'd0);
    tick();
    reset = 1'b1;
    commit_ready = 1'b1;
    put(32'h600, 1'b0, 4'd0, 1'b1, 4'd1, 32'h10, 1'b0, 12'h0, 32'h0, 1'b0);
    at_neg();
    check_eq("t7_discarded", 32'(commit_valid), 32'd0);
    check_eq("t7_rf_we", 32'(rf_we), 32'd0);
    csr_chk("t7_mstatus_rst", 12'h300, 32'h0000_1800);
    csr_chk("t7_mepc_rst", 12'h341, 32'h0);
    check_eq("t7_target_rst", trap_target, 32'h0);
    tick();
    for (int i = 1; i < 4; i++) begin
      put(32'h600 + 32'(i * 4), 1'b0, 4'd0, 1'b1, 4'(i + 1), 32'(i), 1'b0, 12'h0, 32'h0, 1'b0);
      tick();
    end
    idle();
    repeat (6) tick();
    at_neg();
`ifdef WBU_COUNTERS_EN
    csr_chk("t8_mcycle", 12'hB00, 32'd10);
    csr_chk("t8_mcycleh", 12'hB80, 32'd0);
    csr_chk("t8_minstret", 12'hB02, 32'd4);
`else
    csr_chk("t8_mcycle_off", 12'hB00, 32'd0);
    csr_chk("t8_minstret_off", 12'hB02, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
